// File: rtl/spi_host_driver.sv
// rtl/spi_host_driver.sv - SPI mode-0 host master with start/finish run-control sequencer
`timescale 1ns/1ps
module spi_host_driver #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 2,
    parameter int START_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SCK,
    output logic              nSS,
    output logic              start_sign,
    input  logic              finish_sign
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W);
    localparam int START_W = $clog2(START_LEN + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, GAP} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   tx_sh;
    logic [DATA_W-1:0]   rx_sh;
    logic                last_q;
    logic                armed;
    logic                word_end;
    logic                accept;
    logic                div_end;
    logic                gap_end;
    logic                bit_end;
    logic [START_W-1:0]  start_cnt;
    logic                fin_s1, fin_s2, fin_s3;

    assign div_end = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign gap_end = (div_cnt == CNT_W'(CS_GAP - 1));
    assign bit_end = (bit_cnt == BIT_W'(DATA_W - 1));
    assign busy    = (state != IDLE);

    // SPI FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode plus the tx handshake; armed keeps tx_ready low until the first clock after reset
    always_comb begin
        state_nx = state;
        tx_ready = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = armed;
                if (armed && tx_valid) begin
                    accept   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: if (div_end) state_nx = SHIFT;
            SHIFT: if (!SCK && div_end && bit_end) state_nx = NEXT;
            NEXT: begin
                if (last_q) begin
                    state_nx = GAP;
                end else begin
                    tx_ready = 1'b1;
                    if (tx_valid) begin
                        accept   = 1'b1;
                        state_nx = SETUP;
                    end
                end
            end
            GAP:     if (gap_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift datapath: SCK/MOSI/nSS generation, MISO capture, and a one-cycle-late rx_valid pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            word_end <= 1'b0;
            last_q   <= 1'b0;
            armed    <= 1'b0;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            nSS      <= 1'b1;
        end else begin
            armed    <= 1'b1;
            rx_valid <= word_end;
            word_end <= 1'b0;
            if (word_end) rx_data <= rx_sh;
            if (accept) begin
                tx_sh   <= tx_data;
                MOSI    <= tx_data[DATA_W-1];
                last_q  <= tx_last;
                nSS     <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    SETUP: begin
                        if (div_end) begin
                            div_cnt <= '0;
                            SCK     <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (!div_end) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else if (SCK) begin
                            div_cnt <= '0;
                            SCK     <= 1'b0;
                            rx_sh   <= {rx_sh[DATA_W-2:0], MISO};
                            tx_sh   <= tx_sh << 1;
                            MOSI    <= tx_sh[DATA_W-2];
                        end else begin
                            div_cnt <= '0;
                            if (bit_end) begin
                                bit_cnt  <= '0;
                                word_end <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                SCK     <= 1'b1;
                            end
                        end
                    end
                    NEXT: begin
                        div_cnt <= '0;
                        if (last_q) nSS <= 1'b1;
                    end
                    GAP:     div_cnt <= div_cnt + 1'b1;
                    default: div_cnt <= '0;
                endcase
            end
        end
    end

    // start_sign pulse generator; go is ignored while a pulse is already running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_sign <= 1'b0;
            start_cnt  <= '0;
        end else if (go && !start_sign) begin
            start_sign <= 1'b1;
            start_cnt  <= START_W'(START_LEN - 1);
        end else if (start_sign) begin
            if (start_cnt == '0) start_sign <= 1'b0;
            else                 start_cnt  <= start_cnt - 1'b1;
        end
    end

    // finish_sign synchronizer and rising-edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fin_s1 <= 1'b0;
            fin_s2 <= 1'b0;
            fin_s3 <= 1'b0;
            done   <= 1'b0;
        end else begin
            fin_s1 <= finish_sign;
            fin_s2 <= fin_s1;
            fin_s3 <= fin_s2;
            done   <= fin_s2 & ~fin_s3;
        end
    end

endmodule
